// File: rtl/dist_sq_fp_if.sv
// Request/response bundle for the squared-distance stage: six float
// coordinates in, one float result plus status out.
interface dist_sq_fp_if;
   logic        start;
   logic [31:0] x1;
   logic [31:0] y1;
   logic [31:0] z1;
   logic [31:0] x2;
   logic [31:0] y2;
   logic [31:0] z2;
   logic [31:0] res;
   logic        busy;
   logic        done;
   logic        ovf;

   modport master (
      output start, x1, y1, z1, x2, y2, z2,
      input  res, busy, done, ovf
   );

   modport slave (
      input  start, x1, y1, z1, x2, y2, z2,
      output res, busy, done, ovf
   );
endinterface

// File: rtl/dist_sq_fp.sv
// Squared Euclidean distance of two 3-D single-precision points using one
// shared float adder and one shared float multiplier, one operation per cycle.
module dist_sq_fp (
   input  logic          CLK,
   input  logic          RST,
   dist_sq_fp_if.slave   bus
);

   localparam logic [31:0] FP_INF = 32'h7F80_0000;

   localparam logic [3:0] S_IDLE = 4'd0;
   localparam logic [3:0] S_SUBX = 4'd1;
   localparam logic [3:0] S_SUBY = 4'd2;
   localparam logic [3:0] S_SUBZ = 4'd3;
   localparam logic [3:0] S_SQX  = 4'd4;
   localparam logic [3:0] S_SQY  = 4'd5;
   localparam logic [3:0] S_SQZ  = 4'd6;
   localparam logic [3:0] S_ADD1 = 4'd7;
   localparam logic [3:0] S_ADD2 = 4'd8;

   // Truncating add/sub with flush-to-zero; bit 32 of the return flags overflow.
   function automatic logic [32:0] fp_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic sub);
      logic        sa, sb, sl;
      logic [7:0]  ea, eb, el, es, sh;
      logic [23:0] ma, mb, ml, ms, norm;
      logic [24:0] sum;
      logic [4:0]  lz;
      logic        found;
      logic [7:0]  e_res;
      logic [22:0] frac;
      sa = a[31];
      sb = b[31] ^ sub;
      ea = a[30:23];
      eb = b[30:23];
      ma = (ea == 8'h00) ? 24'h0 : {1'b1, a[22:0]};
      mb = (eb == 8'h00) ? 24'h0 : {1'b1, b[22:0]};
      if (ea == 8'hFF || eb == 8'hFF) return {1'b1, FP_INF};
      if ({ea, ma} >= {eb, mb}) begin
         sl = sa; el = ea; ml = ma; es = eb; ms = mb;
      end else begin
         sl = sb; el = eb; ml = mb; es = ea; ms = ma;
      end
      sh = el - es;
      ms = (sh >= 8'd25) ? 24'h0 : (ms >> sh);
      if (sa == sb) sum = {1'b0, ml} + {1'b0, ms};
      else          sum = {1'b0, ml} - {1'b0, ms};
      if (sum == 25'h0) return 33'h0;
      if (sum[24]) begin
         if (el == 8'hFE) return {1'b1, FP_INF};
         e_res = el + 8'd1;
         frac  = sum[23:1];
      end else begin
         lz    = 5'd0;
         found = 1'b0;
         for (int i = 23; i >= 0; i--) begin
            if (!found) begin
               if (sum[i]) found = 1'b1;
               else        lz = lz + 5'd1;
            end
         end
         if ({3'b000, lz} >= el) return 33'h0;
         norm  = sum[23:0] << lz;
         frac  = 23'(norm);
         e_res = el - {3'b000, lz};
      end
      return {1'b0, sl, e_res, frac};
   endfunction

   // Truncating multiply with flush-to-zero; bit 32 of the return flags overflow.
   function automatic logic [32:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
      logic [7:0]  ea, eb;
      logic [47:0] prod;
      logic [9:0]  e_sum;
      logic [22:0] frac;
      ea = a[30:23];
      eb = b[30:23];
      if (ea == 8'hFF || eb == 8'hFF) return {1'b1, FP_INF};
      if (ea == 8'h00 || eb == 8'h00) return 33'h0;
      prod  = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
      e_sum = {2'b00, ea} + {2'b00, eb} + {9'h000, prod[47]};
      if (e_sum >= 10'd382) return {1'b1, FP_INF};
      if (e_sum < 10'd128)  return 33'h0;
      frac = 23'(prod[47] ? (prod >> 24) : (prod >> 23));
      return {1'b0, a[31] ^ b[31], 8'(e_sum - 10'd127), frac};
   endfunction

   logic [3:0]  state;
   logic [31:0] x1_q, y1_q, z1_q, x2_q, y2_q, z2_q;
   logic [31:0] dx, dy, dz, px, py, pz, s_q;
   logic [31:0] res_q;
   logic        busy_q, done_q, ovf_q;

   logic [31:0] add_a, add_b, mul_a;
   logic        add_sub;
   logic [32:0] add_out, mul_out;

   always_comb begin
      // NOTE: every output gets a default first, so no state leaves one unassigned (no latch).
      add_a   = 32'h0;
      add_b   = 32'h0;
      add_sub = 1'b0;
      mul_a   = 32'h0;
      case (state)
         S_SUBX: begin add_a = x1_q; add_b = x2_q; add_sub = 1'b1; end
         S_SUBY: begin add_a = y1_q; add_b = y2_q; add_sub = 1'b1; end
         S_SUBZ: begin add_a = z1_q; add_b = z2_q; add_sub = 1'b1; end
         S_SQX:  mul_a = dx;
         S_SQY:  mul_a = dy;
         S_SQZ:  mul_a = dz;
         S_ADD1: begin add_a = px;  add_b = py; end
         S_ADD2: begin add_a = s_q; add_b = pz; end
         default: ;
      endcase
      add_out = fp_add(add_a, add_b, add_sub);
      mul_out = fp_mul(mul_a, mul_a);
   end

   // NOTE: non-blocking assignments for all state; every register, operand temps included, is reset.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state  <= S_IDLE;
         x1_q   <= '0; y1_q <= '0; z1_q <= '0;
         x2_q   <= '0; y2_q <= '0; z2_q <= '0;
         dx     <= '0; dy <= '0; dz <= '0;
         px     <= '0; py <= '0; pz <= '0;
         s_q    <= '0;
         res_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  x1_q   <= bus.x1; y1_q <= bus.y1; z1_q <= bus.z1;
                  x2_q   <= bus.x2; y2_q <= bus.y2; z2_q <= bus.z2;
                  ovf_q  <= 1'b0;
                  busy_q <= 1'b1;
                  state  <= S_SUBX;
               end
            end
            S_SUBX: begin dx <= add_out[31:0]; ovf_q <= ovf_q | add_out[32]; state <= S_SUBY; end
            S_SUBY: begin dy <= add_out[31:0]; ovf_q <= ovf_q | add_out[32]; state <= S_SUBZ; end
            S_SUBZ: begin dz <= add_out[31:0]; ovf_q <= ovf_q | add_out[32]; state <= S_SQX;  end
            S_SQX:  begin px <= mul_out[31:0]; ovf_q <= ovf_q | mul_out[32]; state <= S_SQY;  end
            S_SQY:  begin py <= mul_out[31:0]; ovf_q <= ovf_q | mul_out[32]; state <= S_SQZ;  end
            S_SQZ:  begin pz <= mul_out[31:0]; ovf_q <= ovf_q | mul_out[32]; state <= S_ADD1; end
            S_ADD1: begin s_q <= add_out[31:0]; ovf_q <= ovf_q | add_out[32]; state <= S_ADD2; end
            S_ADD2: begin
               res_q  <= add_out[31:0];
               ovf_q  <= ovf_q | add_out[32];
               done_q <= 1'b1;
               busy_q <= 1'b0;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.res  = res_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.ovf  = ovf_q;

endmodule

// File: doc/dist_sq_fp.md
Name: dist_sq_fp

Overview:
- Computes the squared Euclidean distance between two 3-D points given as IEEE-754 single-precision floats: (x1-x2)² + (y1-y2)² + (z1-z2)².
- Sits directly upstream of the sqrt stage. Its res output drives the sqrt block's n input.
- One shared float adder and one shared float multiplier are sequenced by an FSM, one operation per cycle.

Parameters:
- None. The format is fixed at 32-bit IEEE-754 single precision: 1 sign bit, 8 exponent bits, 23 mantissa bits.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- x1  in  32  point A, x coordinate (float).
- y1  in  32  point A, y coordinate.
- z1  in  32  point A, z coordinate.
- x2  in  32  point B, x coordinate.
- y2  in  32  point B, y coordinate.
- z2  in  32  point B, z coordinate.
- res  out  32  squared distance (float); feeds sqrt n.
- busy  out  1  high while a computation is in progress.
- done  out  1  one-cycle pulse when res is updated.
- ovf  out  1  sticky for the current result: set if any operation overflowed.

Behaviour:
- Reset (RST=0, asynchronous):
  - state=IDLE.
  - res=32'h0, busy=0, done=0, ovf=0.
  - All internal operand/temp registers cleared.
- Reset asserted mid-computation aborts immediately. No done pulse is produced afterwards.
- FSM states, in order: IDLE, SUBX, SUBY, SUBZ, SQX, SQY, SQZ, ADD1, ADD2, then back to IDLE.
- IDLE:
  - If start=1 at edge k: latch all six inputs, clear ovf, set busy=1, go to SUBX.
  - start=0: stay in IDLE.
- Operations, one per edge:
  - Edge k+1, SUBX: dx=x1-x2.
  - Edge k+2, SUBY: dy=y1-y2.
  - Edge k+3, SUBZ: dz=z1-z2.
  - Edge k+4, SQX: px=dx*dx.
  - Edge k+5, SQY: py=dy*dy.
  - Edge k+6, SQZ: pz=dz*dz.
  - Edge k+7, ADD1: s=px+py.
  - Edge k+8, ADD2: res=s+pz, done=1, busy=0, state=IDLE.
- Latency: res is valid and done=1 in the cycle after edge k+8, i.e. 8 cycles after start is accepted.
- done is high for exactly one cycle.
- res holds its value until the next ADD2 or reset. Inputs may change freely after edge k.
- start while busy=1 is ignored and is not queued.
- start in the same cycle as done=1: accepted, since state is IDLE. busy rises again at that edge.
- Float arithmetic rules:
  - Zero/denormal: any operand with exponent 0 is treated as ±0 (flush-to-zero). A result whose exponent underflows below 1 is 32'h0.
  - Rounding: truncate (round toward zero) for both add and multiply.
  - Add/sub:
    - Subtraction negates the sign of the second operand.
    - Align to the larger exponent, shifting the smaller mantissa right with implicit 1. Shifts of 25 or more give 0.
    - Add or subtract the 24-bit mantissas, then normalize (leading-one detect, left shift).
    - An exact-zero result is +0 (32'h0).
  - Multiply:
    - 24x24 mantissa product, exponent e1+e2-127.
    - Normalize by 1 if product bit 47 is set.
    - Sign = s1 XOR s2. Squares are therefore always non-negative.
  - Overflow: exponent ≥255 after any op → result 32'h7F800000 (+inf), and ovf=1 with the final result.
  - Inf/NaN inputs (exponent 255) are treated as overflow: final res=32'h7F800000, ovf=1.
- res sign is always 0.

Test Plan:
- Reset: hold RST=0 while toggling start. → res=0, busy=0, done=0, ovf=0 throughout.
- A=(0,0,0), B=(3.0,4.0,0). start pulse at edge k. → done at k+8, res=32'h41C80000 (25.0), ovf=0; busy high for exactly 8 cycles.
- A=(0.5,0.5,0.5) i.e. 32'h3F000000 ×3, B=0. → res=32'h3F400000 (0.75), the sqrt stage's reference operand.
- A=B=(1.0,2.0,3.0). → res=32'h0. Then A=(1.5,0,0), B=0 started in the done cycle. → second result 32'h40100000 (2.25), 8 cycles later.
- x1=32'h60AD78EC (1e20), x2=32'hE0AD78EC (-1e20), rest 0. → res=32'h7F800000, ovf=1. A following normal run clears ovf.
- start held high continuously for 30 cycles with (3,4,0) → done pulses every 9 cycles, res=32'h41C80000 each time. Drop RST at cycle 4 of a run → outputs zero immediately and no done appears.
